// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, followed by a single-cycle register file write.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  rd,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] win
);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t      state, state_n;
    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic [4:0]  cnt;
    // opa: multiplicand, or dividend shifting out / quotient shifting in
    // opb: multiplier shifting right, or fixed divisor
    // acc: 64-bit product, or partial remainder in acc[31:0]
    logic [31:0] opa, opb;
    logic [63:0] acc;

    logic [32:0] sum, shl;
    logic [31:0] diff;
    logic        qbit;
    logic [63:0] acc_n;
    logic [31:0] opa_n, opb_n, result;

    assign busy = (state != IDLE);

    always_comb begin
        sum    = {1'b0, acc[63:32]} + (opb[0] ? {1'b0, opa} : 33'd0);
        shl    = {acc[31:0], opa[31]};
        qbit   = (shl >= {1'b0, opb});
        diff   = shl[31:0] - opb;
        acc_n  = acc;
        opa_n  = opa;
        opb_n  = opb;
        if (!op_q[1]) begin
            // carry out of the add lands in bit 63 after the shift
            acc_n = {sum, acc[31:1]};
            opb_n = opb >> 1;
        end else begin
            acc_n = {32'd0, (qbit ? diff : shl[31:0])};
            opa_n = {opa[30:0], qbit};
        end
        case (op_q)
            2'b00:   result = acc_n[31:0];
            2'b01:   result = acc_n[63:32];
            2'b10:   result = opa_n;
            default: result = acc_n[31:0];
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == 5'd0) state_n = WB;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= 2'd0;
            rd_q  <= 5'd0;
            cnt   <= 5'd0;
            opa   <= 32'd0;
            opb   <= 32'd0;
            acc   <= 64'd0;
            done  <= 1'b0;
            we    <= 1'b0;
            waddr <= 5'd0;
            win   <= 32'd0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    rd_q <= rd;
                    opa  <= a;
                    opb  <= b;
                    acc  <= 64'd0;
                    cnt  <= 5'd31;
                end
                RUN: begin
                    acc <= acc_n;
                    opa <= opa_n;
                    opb <= opb_n;
                    cnt <= cnt - 5'd1;
                    // final iteration: register the write so it is presented in WB
                    if (cnt == 5'd0) begin
                        done  <= 1'b1;
                        we    <= (rd_q != 5'd0);
                        waddr <= rd_q;
                        win   <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
